mem_resp_ctrl: RTL and testbench

Memory-side responder for the cache's block-refill/write-back interface. It accepts one block read or write request at a time from the cache over a valid/ready handshake, models a fixed access latency, owns the backing block store, and returns a one-cycle response pulse carrying the block. It replaces the zero-latency memory model behind cache_data so that the cache can be exercised against realistic miss penalties.

---
 rtl/mem_resp_ctrl_if.sv | 26 ++
 rtl/mem_resp_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_resp_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_ctrl_if.sv
// Cache <-> memory responder channel: block request handshake plus one-cycle response strobe.
// The responder takes the slave modport; the cache (or a bench) drives the master side.
interface mem_resp_ctrl_if #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [PA_WIDTH-1:0]  req_addr;
  logic [BLK_WIDTH-1:0] req_wr_blk;
  logic                 rsp_valid;
  logic                 rsp_we;
  logic [BLK_WIDTH-1:0] rsp_rd_blk;
  logic                 busy;

  modport master (
    output req_valid, req_we, req_addr, req_wr_blk,
    input  req_ready, rsp_valid, rsp_we, rsp_rd_blk, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wr_blk,
    output req_ready, rsp_valid, rsp_we, rsp_rd_blk, busy
  );
endinterface

// File: rtl/mem_resp_ctrl.sv
// Block memory responder: one request in flight, response strobe LATENCY cycles after accept.
// Backpressure: req_ready only in IDLE, so throughput is one request per LATENCY+1 cycles.
module mem_resp_ctrl #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512,
  parameter int IDX_W     = 8,
  parameter int LATENCY   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_resp_ctrl_if.slave   mem_if
);

  localparam int NBLK = 1 << IDX_W;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_resp_ctrl: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 we_q, we_d;
  logic [BLK_WIDTH-1:0] blk_q, blk_d;
  logic                 rsp_we_q;
  logic [BLK_WIDTH-1:0] rsp_blk_q, rsp_blk_d;
  logic [NBLK-1:0]      vld_q;
  logic [BLK_WIDTH-1:0] mem_q [NBLK];

  logic                 handshake;
  logic                 commit;
  logic [IDX_W-1:0]     req_idx;
  logic                 addr_unused;

  // Offset and upper address bits intentionally alias onto the same block.
  assign req_idx     = mem_if.req_addr[5+IDX_W:6];
  assign addr_unused = ^{mem_if.req_addr[PA_WIDTH-1:6+IDX_W], mem_if.req_addr[5:0]};

  assign mem_if.req_ready  = rst_n & (state_q == IDLE);
  assign mem_if.rsp_valid  = (state_q == RESP);
  assign mem_if.rsp_we     = rsp_we_q;
  assign mem_if.rsp_rd_blk = rsp_blk_q;
  assign mem_if.busy       = (state_q != IDLE);

  assign handshake = mem_if.req_valid & mem_if.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    blk_d   = blk_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          idx_d = req_idx;
          we_d  = mem_if.req_we;
          blk_d = mem_if.req_wr_blk;
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d copies carry either fresh inputs (LATENCY=1) or the latched request.
  always_comb begin
    rsp_blk_d = '0;
    if (we_d) begin
      rsp_blk_d = blk_d;
    end else if (vld_q[idx_d]) begin
      rsp_blk_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      blk_q     <= '0;
      rsp_we_q  <= 1'b0;
      rsp_blk_q <= '0;
      vld_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      blk_q   <= blk_d;
      if (commit) begin
        rsp_we_q  <= we_d;
        rsp_blk_q <= rsp_blk_d;
        if (we_d) begin
          vld_q[idx_d] <= 1'b1;
        end
      end
    end
  end

  // Storage is not reset; commit cannot fire while reset holds the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (commit && we_d) begin
      mem_q[idx_d] <= blk_d;
    end
  end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench for mem_resp_ctrl: table of block requests plus hand-written sequences
// for back-to-back acceptance, reset mid-request and a LATENCY=1 instance.
module tb_mem_resp_ctrl;

  typedef struct {
    string        name;
    logic         we;
    logic [31:0]  addr;
    logic [511:0] wblk;
    logic [511:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic sel;
  logic valid;
  logic t_we;
  logic [31:0]  t_addr;
  logic [511:0] t_blk;
  int checks;
  int errors;
  int cyc;

  localparam logic [511:0] ALL_FF = {64{8'hff}};
  localparam logic [511:0] ALL_AA = {64{8'haa}};
  localparam logic [511:0] ALL_CC = {64{8'hcc}};
  localparam logic [511:0] ALL_55 = {64{8'h55}};
  localparam logic [511:0] ALL_33 = {64{8'h33}};
  localparam logic [511:0] ALL_0F = {64{8'h0f}};

  mem_resp_ctrl_if #(.PA_WIDTH(32), .BLK_WIDTH(512)) if4 ();
  mem_resp_ctrl_if #(.PA_WIDTH(32), .BLK_WIDTH(512)) if1 ();

  mem_resp_ctrl #(.PA_WIDTH(32), .BLK_WIDTH(512), .IDX_W(8), .LATENCY(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (if4)
  );

  mem_resp_ctrl #(.PA_WIDTH(32), .BLK_WIDTH(512), .IDX_W(8), .LATENCY(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (if1)
  );

  assign if4.req_valid  = valid & ~sel;
  assign if4.req_we     = t_we;
  assign if4.req_addr   = t_addr;
  assign if4.req_wr_blk = t_blk;
  assign if1.req_valid  = valid & sel;
  assign if1.req_we     = t_we;
  assign if1.req_addr   = t_addr;
  assign if1.req_wr_blk = t_blk;

  logic         s_ready, s_rsp_valid, s_rsp_we, s_busy;
  logic [511:0] s_rsp_blk;
  assign s_ready     = sel ? if1.req_ready  : if4.req_ready;
  assign s_rsp_valid = sel ? if1.rsp_valid  : if4.rsp_valid;
  assign s_rsp_we    = sel ? if1.rsp_we     : if4.rsp_we;
  assign s_busy      = sel ? if1.busy       : if4.busy;
  assign s_rsp_blk   = sel ? if1.rsp_rd_blk : if4.rsp_rd_blk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One request; checks latency, ready low while busy, single-cycle pulse and held data.
  task automatic run_req(input string nm, input logic we, input logic [31:0] addr,
                         input logic [511:0] wblk, input logic [511:0] exp, input int lat);
    int  n;
    bit  seen;
    bit  rdy_leak;
    @(negedge clk);
    check({nm, " ready before"}, 512'(s_ready), 512'd1);
    valid  = 1'b1;
    t_we   = we;
    t_addr = addr;
    t_blk  = wblk;
    @(posedge clk);
    #1;
    valid  = 1'b0;
    t_we   = ~we;
    t_addr = ~addr;
    t_blk  = ~wblk;
    seen = 0;
    rdy_leak = 0;
    n = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (s_ready) rdy_leak = 1;
      if (s_rsp_valid) begin
        seen = 1;
        n = i;
      end
    end
    check({nm, " rsp seen"}, 512'(seen), 512'd1);
    check({nm, " latency"}, 512'(n), 512'(lat));
    check({nm, " ready low while busy"}, 512'(rdy_leak), 512'd0);
    check({nm, " rsp_we"}, 512'(s_rsp_we), 512'(we));
    check({nm, " rsp_rd_blk"}, s_rsp_blk, exp);
    @(negedge clk);
    check({nm, " rsp one cycle"}, 512'(s_rsp_valid), 512'd0);
    check({nm, " ready after"}, 512'(s_ready), 512'd1);
    check({nm, " data held"}, s_rsp_blk, exp);
  endtask

  vec_t vec [11];
  logic [511:0] b2b_dat [3];
  int acc [3];

  initial begin
    int k, r, rdy_cnt;
    bit stray;
    checks = 0;
    errors = 0;
    cyc    = 0;
    sel    = 1'b0;
    valid  = 1'b0;
    t_we   = 1'b0;
    t_addr = '0;
    t_blk  = '0;
    rst_n  = 1'b0;

    vec[0]  = '{"rd0 empty",   1'b0, 32'h0000_0000, '0,     '0};
    vec[1]  = '{"rd 0x80",     1'b0, 32'h0000_0080, '0,     ALL_CC};
    vec[2]  = '{"rd 0x40",     1'b0, 32'h0000_0040, '0,     ALL_AA};
    vec[3]  = '{"rd 0x00",     1'b0, 32'h0000_0000, '0,     ALL_FF};
    vec[4]  = '{"wr 0x4000",   1'b1, 32'h0000_4000, ALL_55, ALL_55};
    vec[5]  = '{"rd alias 0",  1'b0, 32'h0000_0000, '0,     ALL_55};
    vec[6]  = '{"rd off 0x13", 1'b0, 32'h0000_0013, '0,     ALL_55};
    vec[7]  = '{"rd idx255",   1'b0, 32'h0000_3fc0, '0,     '0};
    vec[8]  = '{"wr idx255",   1'b1, 32'hffff_fffc, ALL_0F, ALL_0F};
    vec[9]  = '{"rd idx255 a", 1'b0, 32'h0000_3fc0, '0,     ALL_0F};
    vec[10] = '{"rd 0x40 kept", 1'b0, 32'h0000_0040, '0,    ALL_AA};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst ready", 512'(s_ready), 512'd0);
    check("rst rsp_valid", 512'(s_rsp_valid), 512'd0);
    check("rst busy", 512'(s_busy), 512'd0);
    check("rst rsp_we", 512'(s_rsp_we), 512'd0);
    check("rst rsp_blk", s_rsp_blk, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst ready", 512'(s_ready), 512'd1);

    run_req(vec[0].name, vec[0].we, vec[0].addr, vec[0].wblk, vec[0].exp, 4);

    // Back-to-back writes with req_valid held high
    b2b_dat[0] = ALL_FF;
    b2b_dat[1] = ALL_AA;
    b2b_dat[2] = ALL_CC;
    k = 0;
    r = 0;
    rdy_cnt = 0;
    @(negedge clk);
    valid  = 1'b1;
    t_we   = 1'b1;
    t_addr = 32'h0;
    t_blk  = b2b_dat[0];
    for (int i = 0; i < 40 && r < 3; i++) begin
      if (s_rsp_valid) begin
        check("b2b rsp_we", 512'(s_rsp_we), 512'd1);
        check("b2b rsp_blk", s_rsp_blk, b2b_dat[r]);
        r++;
      end
      if (s_ready) rdy_cnt++;
      if (s_ready && k < 3) begin
        acc[k] = cyc + 1;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) begin
          t_addr = 32'(k) << 6;
          t_blk  = b2b_dat[k];
        end else begin
          valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b responses", 512'(r), 512'd3);
    check("b2b accepts", 512'(k), 512'd3);
    check("b2b ready pulses", 512'(rdy_cnt), 512'd3);
    check("b2b gap1", 512'(acc[1] - acc[0]), 512'd5);
    check("b2b gap2", 512'(acc[2] - acc[1]), 512'd5);

    for (int i = 1; i < 11; i++) begin
      run_req(vec[i].name, vec[i].we, vec[i].addr, vec[i].wblk, vec[i].exp, 4);
    end

    // Reset two cycles into a pending write
    @(negedge clk);
    valid  = 1'b1;
    t_we   = 1'b1;
    t_addr = 32'h40;
    t_blk  = ALL_33;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 512'(s_busy), 512'd0);
    check("midrst ready", 512'(s_ready), 512'd0);
    check("midrst rsp_blk", s_rsp_blk, '0);
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (s_rsp_valid) stray = 1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (s_rsp_valid) stray = 1;
    end
    check("midrst no rsp", 512'(stray), 512'd0);
    run_req("rd 0x40 after rst", 1'b0, 32'h40, '0, '0, 4);
    run_req("rd 0x00 after rst", 1'b0, 32'h00, '0, '0, 4);

    // LATENCY=1 instance
    sel = 1'b1;
    run_req("L1 wr 0x80", 1'b1, 32'h80, ALL_CC, ALL_CC, 1);
    run_req("L1 rd 0x80", 1'b0, 32'h80, '0, ALL_CC, 1);
    @(negedge clk);
    valid  = 1'b1;
    t_we   = 1'b0;
    t_addr = 32'h0;
    @(posedge clk);
    #1;
    t_addr = 32'h80;
    @(negedge clk);
    check("L1 rsp next cycle", 512'(s_rsp_valid), 512'd1);
    check("L1 ready in RESP", 512'(s_ready), 512'd0);
    check("L1 busy in RESP", 512'(s_busy), 512'd1);
    check("L1 rd empty", s_rsp_blk, '0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    check("L1 ready back", 512'(s_ready), 512'd1);
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_rsp_valid) stray = 1;
    end
    check("L1 ignored while busy", 512'(stray), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
